// File: rtl/lock_ctrl_pkg.sv
// Shared types and default constants for the combination-lock attempt sequencer.
package lock_ctrl_pkg;

  localparam int CODE_W_DEF      = 6;
  localparam int MAX_FAIL_DEF    = 3;
  localparam int LOCKOUT_CYC_DEF = 64;
  localparam int FAIL_CNT_W      = 4;

  typedef enum logic [2:0] {
    st_idle,
    st_clear,
    st_shift,
    st_check,
    st_lockout
  } lock_seq_state_t;

endpackage

// File: rtl/lock_code_piso.sv
// Parallel-in serial-out code shifter; msb is a registered serial bit that
// drops to 0 whenever no shift is requested.
module lock_code_piso #(
  parameter int W = 6
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic         load,
  input  logic         shift,
  input  logic         count,
  input  logic [W-1:0] code,
  output logic         msb,
  output logic         last
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  sreg;
  logic [CW-1:0] cnt;

  // The serial bit is launched one cycle ahead of the shift state it belongs to.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      sreg <= '0;
      cnt  <= '0;
      msb  <= 1'b0;
    end else begin
      if (load) begin
        sreg <= code;
        cnt  <= CW'(W - 1);
      end else begin
        if (shift) sreg <= {sreg[W-2:0], 1'b0};
        if (count) cnt  <= cnt - CW'(1);
      end
      msb <= shift ? sreg[W-1] : 1'b0;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/lock_attempt_sequencer.sv
// Drives the serial lock FSM from a parallel code word, reports pass/fail and
// enforces a lockout after repeated failures.
module lock_attempt_sequencer
  import lock_ctrl_pkg::*;
#(
  parameter int CODE_W      = CODE_W_DEF,
  parameter int MAX_FAIL    = MAX_FAIL_DEF,
  parameter int LOCKOUT_CYC = LOCKOUT_CYC_DEF
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  START,
  input  logic [CODE_W-1:0]     CODE,
  input  logic                  UNLK_IN,
  output logic                  LOCK_CLR,
  output logic                  X_OUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  PASS,
  output logic                  LOCKED_OUT,
  output logic [FAIL_CNT_W-1:0] FAIL_CNT
);

  localparam int LO_W = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
  localparam logic [LO_W-1:0]       LO_LOAD  = LO_W'(LOCKOUT_CYC - 1);
  localparam logic [FAIL_CNT_W-1:0] FAIL_MAX = FAIL_CNT_W'(MAX_FAIL);

  lock_seq_state_t state_q, state_d;
  logic [LO_W-1:0] lo_cnt;
  logic            piso_load, piso_shift, piso_count, piso_last;
  logic            fail_hit;

  assign fail_hit   = ((FAIL_CNT + FAIL_CNT_W'(1)) == FAIL_MAX);
  assign piso_load  = (state_q == st_idle) && START;
  assign piso_shift = (state_q == st_clear) || ((state_q == st_shift) && !piso_last);
  assign piso_count = (state_q == st_shift);

  lock_code_piso #(.W(CODE_W)) u_piso (
    .CLK   (CLK),
    .CLR   (CLR),
    .load  (piso_load),
    .shift (piso_shift),
    .count (piso_count),
    .code  (CODE),
    .msb   (X_OUT),
    .last  (piso_last)
  );

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) state_q <= st_idle;
    else      state_q <= state_d;
  end

  // CHECK decides on the PASS register, which latched UNLK_IN on entry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      st_idle:    if (START) state_d = st_clear;
      st_clear:   state_d = st_shift;
      st_shift:   if (piso_last) state_d = st_check;
      st_check:   state_d = (!PASS && fail_hit) ? st_lockout : st_idle;
      st_lockout: if (lo_cnt == '0) state_d = st_idle;
      default:    state_d = st_idle;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      LOCK_CLR   <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      PASS       <= 1'b0;
      LOCKED_OUT <= 1'b0;
      FAIL_CNT   <= '0;
      lo_cnt     <= '0;
    end else begin
      LOCK_CLR   <= (state_d == st_clear);
      BUSY       <= (state_d != st_idle);
      DONE       <= (state_d == st_check);
      LOCKED_OUT <= (state_d == st_lockout);
      if (state_d == st_check) PASS <= UNLK_IN;
      case (state_q)
        st_check: begin
          if (PASS) begin
            FAIL_CNT <= '0;
          end else if (fail_hit) begin
            FAIL_CNT <= FAIL_MAX;
            lo_cnt   <= LO_LOAD;
          end else begin
            FAIL_CNT <= FAIL_CNT + FAIL_CNT_W'(1);
          end
        end
        st_lockout: begin
          if (lo_cnt == '0) FAIL_CNT <= '0;
          else              lo_cnt   <= lo_cnt - LO_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lock_attempt_sequencer.sv
// Directed bench: a small serial lock model for code 101101 driven by the sequencer.
module tb_lock_attempt_sequencer;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic       START = 1'b0;
  logic [5:0] CODE = 6'b0;
  logic       UNLK_IN;
  logic       LOCK_CLR, X_OUT, BUSY, DONE, PASS, LOCKED_OUT;
  logic [3:0] FAIL_CNT;

  int n_checks = 0;
  int n_pass   = 0;

  logic [5:0] good_code = 6'b101101;
  logic [5:0] bad_code  = 6'b000000;

  always #5 CLK = ~CLK;

  lock_attempt_sequencer #(
    .CODE_W      (6),
    .MAX_FAIL    (3),
    .LOCKOUT_CYC (8)
  ) dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .START      (START),
    .CODE       (CODE),
    .UNLK_IN    (UNLK_IN),
    .LOCK_CLR   (LOCK_CLR),
    .X_OUT      (X_OUT),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .PASS       (PASS),
    .LOCKED_OUT (LOCKED_OUT),
    .FAIL_CNT   (FAIL_CNT)
  );

  // Lock model: counts consecutive matching bits since the last clear.
  int   matched = 0;
  logic err = 1'b0;

  always @(posedge CLK) begin
    if (LOCK_CLR) begin
      matched <= 0;
      err     <= 1'b0;
    end else if (!err && matched < 6) begin
      if (X_OUT == good_code[5-matched]) matched <= matched + 1;
      else                               err     <= 1'b1;
    end
  end

  assign UNLK_IN = !err && ((matched == 6) || (matched == 5 && X_OUT == good_code[0]));

  task automatic run_attempt(input logic [5:0] code, input logic exp_pass, input string name);
    START = 1'b1;
    CODE  = code;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    n_checks++;
    if ({LOCK_CLR, X_OUT, BUSY, DONE} !== 4'b1010)
      $display("[TB] FAIL %s clear_cycle: got %b want 1010", name, {LOCK_CLR, X_OUT, BUSY, DONE});
    else n_pass++;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      n_checks++;
      if ({LOCK_CLR, X_OUT, BUSY, DONE} !== {1'b0, code[5-k], 1'b1, 1'b0})
        $display("[TB] FAIL %s shift_bit%0d: got %b want %b", name, k,
                 {LOCK_CLR, X_OUT, BUSY, DONE}, {1'b0, code[5-k], 1'b1, 1'b0});
      else n_pass++;
    end
    @(negedge CLK);
    n_checks++;
    if ({DONE, PASS, X_OUT, LOCK_CLR} !== {1'b1, exp_pass, 2'b00})
      $display("[TB] FAIL %s done_cycle: got %b want %b", name,
               {DONE, PASS, X_OUT, LOCK_CLR}, {1'b1, exp_pass, 2'b00});
    else n_pass++;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    n_checks++;
    if ({LOCK_CLR, X_OUT, BUSY, DONE, PASS, LOCKED_OUT, FAIL_CNT} !== 10'b0)
      $display("[TB] FAIL reset_values: got %b want 0", {LOCK_CLR, X_OUT, BUSY, DONE, PASS, LOCKED_OUT, FAIL_CNT});
    else n_pass++;
    CLR = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_correct_code();
    run_attempt(good_code, 1'b1, "correct");
    @(negedge CLK);
    n_checks++;
    if ({BUSY, DONE, PASS, FAIL_CNT} !== {3'b001, 4'd0})
      $display("[TB] FAIL correct_after: got %b want 0010000", {BUSY, DONE, PASS, FAIL_CNT});
    else n_pass++;
  endtask

  task automatic test_single_wrong();
    run_attempt(bad_code, 1'b0, "wrong");
    @(negedge CLK);
    n_checks++;
    if ({BUSY, FAIL_CNT} !== {1'b0, 4'd1})
      $display("[TB] FAIL wrong_failcnt: got %b want 00001", {BUSY, FAIL_CNT});
    else n_pass++;
    run_attempt(good_code, 1'b1, "recover");
    @(negedge CLK);
    n_checks++;
    if (FAIL_CNT !== 4'd0) $display("[TB] FAIL recover_failcnt: got %0d want 0", FAIL_CNT);
    else n_pass++;
  endtask

  task automatic test_lockout();
    for (int a = 0; a < 3; a++) begin
      run_attempt(bad_code, 1'b0, "lock_wrong");
      if (a < 2) begin
        @(negedge CLK);
        n_checks++;
        if ({LOCKED_OUT, FAIL_CNT} !== {1'b0, 4'(a + 1)})
          $display("[TB] FAIL lock_failcnt%0d: got %b want %b", a, {LOCKED_OUT, FAIL_CNT}, {1'b0, 4'(a + 1)});
        else n_pass++;
      end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      n_checks++;
      if ({LOCKED_OUT, BUSY, LOCK_CLR, DONE, FAIL_CNT} !== {4'b1100, 4'd3})
        $display("[TB] FAIL lockout_cycle%0d: got %b want 11000011", i, {LOCKED_OUT, BUSY, LOCK_CLR, DONE, FAIL_CNT});
      else n_pass++;
      if (i == 2) begin
        START = 1'b1;
        CODE  = good_code;
      end
      if (i == 3) START = 1'b0;
    end
    @(negedge CLK);
    n_checks++;
    if ({LOCKED_OUT, BUSY, LOCK_CLR, FAIL_CNT} !== 7'b0)
      $display("[TB] FAIL lockout_exit: got %b want 0000000", {LOCKED_OUT, BUSY, LOCK_CLR, FAIL_CNT});
    else n_pass++;
    run_attempt(good_code, 1'b1, "post_lockout");
    @(negedge CLK);
  endtask

  task automatic test_start_busy();
    int clr_seen  = 0;
    int done_seen = 0;
    START = 1'b1;
    CODE  = good_code;
    @(posedge CLK);
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge CLK);
      clr_seen  += int'(LOCK_CLR);
      done_seen += int'(DONE);
      if (cyc >= 2 && cyc <= 7) begin
        n_checks++;
        if (X_OUT !== good_code[7-cyc])
          $display("[TB] FAIL busy_xout%0d: got %b want %b", cyc, X_OUT, good_code[7-cyc]);
        else n_pass++;
      end
      if (cyc == 4) CODE = bad_code;
      if (cyc == 8) begin
        n_checks++;
        if ({DONE, PASS} !== 2'b11) $display("[TB] FAIL busy_done: got %b want 11", {DONE, PASS});
        else n_pass++;
      end
    end
    n_checks++;
    if (clr_seen != 1 || done_seen != 1 || BUSY !== 1'b0)
      $display("[TB] FAIL busy_single: got clr=%0d done=%0d busy=%b want 1 1 0", clr_seen, done_seen, BUSY);
    else n_pass++;
    @(negedge CLK);
    n_checks++;
    if (LOCK_CLR !== 1'b1) $display("[TB] FAIL busy_second_clr: got %b want 1", LOCK_CLR);
    else n_pass++;
    @(negedge CLK);
    @(negedge CLK);
    START = 1'b0;
    repeat (5) @(negedge CLK);
    n_checks++;
    if ({DONE, PASS} !== 2'b10) $display("[TB] FAIL busy_second_done: got %b want 10", {DONE, PASS});
    else n_pass++;
    @(negedge CLK);
    run_attempt(good_code, 1'b1, "busy_cleanup");
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_shift();
    int seen = 0;
    START = 1'b1;
    CODE  = good_code;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    CLR = 1'b0;
    #1;
    n_checks++;
    if ({LOCK_CLR, X_OUT, BUSY, DONE, PASS, LOCKED_OUT, FAIL_CNT} !== 10'b0)
      $display("[TB] FAIL midreset_values: got %b want 0", {LOCK_CLR, X_OUT, BUSY, DONE, PASS, LOCKED_OUT, FAIL_CNT});
    else n_pass++;
    @(negedge CLK);
    CLR = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      seen += int'(DONE) + int'(BUSY);
    end
    n_checks++;
    if (seen != 0) $display("[TB] FAIL midreset_no_done: got %0d active cycles want 0", seen);
    else n_pass++;
    run_attempt(good_code, 1'b1, "after_reset");
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    run_attempt(good_code, 1'b1, "b2b_first");
    @(negedge CLK);
    n_checks++;
    if ({DONE, BUSY} !== 2'b00) $display("[TB] FAIL b2b_gap: got %b want 00", {DONE, BUSY});
    else n_pass++;
    run_attempt(bad_code, 1'b0, "b2b_second");
    @(negedge CLK);
  endtask

  initial begin
    $display("[TB] starting lock_attempt_sequencer bench");
    test_reset();
    test_correct_code();
    test_single_wrong();
    test_lockout();
    test_start_busy();
    test_reset_mid_shift();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
